// File: rtl/io_bridge_pkg.sv
// Shared helpers for the processor I/O bridge: address and FIFO entry widths
// derived from the bridge parameters.
package io_bridge_pkg;

    localparam int unsigned NubitsDefault = 16;
    localparam int unsigned NuioinDefault = 2;
    localparam int unsigned NuioouDefault = 2;
    localparam int unsigned OdepthDefault = 4;

    // Address width for n ports; a single port still gets one select bit.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One output FIFO entry holds {address, data}.
    function automatic int unsigned entry_w(input int unsigned nubits, input int unsigned nuioou);
        return nubits + addr_w(nuioou);
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO for the output queue. Depth must be a power of two so the
// pointers wrap naturally; a push on a full FIFO is accepted only with a pop.
module io_fifo
    import io_bridge_pkg::*;
#(
    parameter int unsigned Depth = OdepthDefault,
    parameter int unsigned Width = 18,
    localparam int unsigned PtrW = addr_w(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pop is evaluated first so a full FIFO can take a push in the same cycle;
    // an empty FIFO ignores the pop, so there is no fall-through.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/io_bridge.sv
// Peripheral side of the processor I/O port: per-address input holding
// registers with interrupt on capture, and an output write queue.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int unsigned NUBITS = NubitsDefault,
    parameter int unsigned NUIOIN = NuioinDefault,
    parameter int unsigned NUIOOU = NuioouDefault,
    parameter int unsigned ODEPTH = OdepthDefault,
    localparam int unsigned AinW  = addr_w(NUIOIN),
    localparam int unsigned AoutW = addr_w(NUIOOU),
    localparam int unsigned EntW  = entry_w(NUBITS, NUIOOU)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_in,
    input  logic [AinW-1:0]   addr_in,
    output logic [NUBITS-1:0] io_in,
    input  logic              out_en,
    input  logic [AoutW-1:0]  addr_out,
    input  logic [NUBITS-1:0] io_out,
    output logic              itr,
    input  logic [NUBITS-1:0] xi_data,
    input  logic [AinW-1:0]   xi_addr,
    input  logic              xi_valid,
    output logic              xi_ready,
    output logic [NUBITS-1:0] xo_data,
    output logic [AoutW-1:0]  xo_addr,
    output logic              xo_valid,
    input  logic              xo_ready,
    output logic              ovf
);

    localparam int unsigned CntW = addr_w(ODEPTH) + 1;

    logic [NUBITS-1:0] hold_q [NUIOIN];
    logic [NUBITS-1:0] hold_d [NUIOIN];
    logic [NUIOIN-1:0] full_q, full_d;
    logic              itr_q, itr_d;
    logic              ovf_q, ovf_d;
    logic              xi_fire;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EntW-1:0]   fifo_wdata, fifo_rdata;
    logic [CntW-1:0]   fifo_count;

    // ---------------- input holding registers ----------------
    assign xi_ready = ~full_q[xi_addr];
    assign xi_fire  = xi_valid & xi_ready;
    assign io_in    = hold_q[addr_in];

    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        if (req_in) begin
            full_d[addr_in] = 1'b0;
        end
        // Capture after the read clear so a same-cycle set wins.
        if (xi_fire) begin
            hold_d[xi_addr] = xi_data;
            full_d[xi_addr] = 1'b1;
        end
    end

    assign itr_d = xi_fire;

    // ---------------- output queue ----------------
    assign fifo_wdata = {addr_out, io_out};
    assign fifo_push  = out_en;
    assign fifo_pop   = xo_ready & ~fifo_empty;
    assign ovf_d      = ovf_q | (out_en & fifo_full & ~fifo_pop);

    assign xo_valid = (fifo_count != '0);
    assign xo_addr  = fifo_rdata[EntW-1 -: AoutW];
    assign xo_data  = fifo_rdata[NUBITS-1:0];
    assign itr      = itr_q;
    assign ovf      = ovf_q;

    io_fifo #(
        .Depth (ODEPTH),
        .Width (EntW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUIOIN); i++) begin
                hold_q[i] <= '0;
            end
            full_q <= '0;
            itr_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
            itr_q  <= itr_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule
